// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: schedules operands and OPMODE for a DSP48E2 dot product with bias.
// Define DSP_MAC_BIAS_EN to load the latched bias through C on the first product.
module dsp_mac_sequencer #(
    parameter int LEN_W   = 8,
    parameter int LAT     = 3,
    parameter int OPM_DLY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [47:0]       bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [17:0]       in_a,
    input  logic [17:0]       in_b,
    output logic [17:0]       dsp_a,
    output logic [17:0]       dsp_b,
    output logic [47:0]       dsp_c,
    output logic [8:0]        dsp_opmode,
    input  logic [47:0]       dsp_p,
    output logic [47:0]       result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
`ifdef DSP_MAC_BIAS_EN
    localparam logic [8:0] OPM_FIRST = 9'h035;
`else
    localparam logic [8:0] OPM_FIRST = 9'h005;
`endif
    localparam logic [8:0] OPM_ACC  = 9'h025;
    localparam logic [8:0] OPM_NONE = 9'h000;
    localparam int DW = $clog2(LAT + OPM_DLY + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(LAT + OPM_DLY);

    state_t state, state_n;
    logic [LEN_W-1:0] len_q, cnt;
    logic [DW-1:0] dcnt;
    logic [47:0] bias_q;
    logic first, fire, last, accept;
    logic [8:0] tag;
    logic [8:0] opm_sr [0:OPM_DLY];

    assign accept = state == IDLE && start && len != '0;
    assign fire = in_valid & in_ready;
    assign last = fire && cnt == len_q - 1'b1;
    assign dsp_opmode = opm_sr[OPM_DLY];
`ifdef DSP_MAC_BIAS_EN
    assign dsp_c = bias_q;
`else
    logic unused_bias;
    assign unused_bias = ^bias_q;
    assign dsp_c = '0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? RUN : IDLE;
            RUN:     state_n = last ? DRAIN : RUN;
            DRAIN:   state_n = dcnt == '0 ? DONE : DRAIN;
            DONE:    state_n = result_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == RUN;
        busy = state != IDLE;
        result_valid = state == DONE;
        tag = state == IDLE ? OPM_NONE : (fire && !first) ? OPM_FIRST : OPM_ACC;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dsp_a <= '0;
            dsp_b <= '0;
            len_q <= '0;
            cnt <= '0;
            dcnt <= '0;
            bias_q <= '0;
            first <= 1'b0;
            result <= '0;
            for (int i = 0; i <= OPM_DLY; i++) opm_sr[i] <= OPM_NONE;
        end else begin
            dsp_a <= fire ? in_a : '0;
            dsp_b <= fire ? in_b : '0;
            // tag leaves with the operands and trails them into the ALU
            opm_sr[0] <= tag;
            for (int i = 1; i <= OPM_DLY; i++) opm_sr[i] <= opm_sr[i-1];
            if (accept) begin
                len_q <= len;
                bias_q <= bias;
                cnt <= '0;
                first <= 1'b0;
            end
            if (fire) begin
                cnt <= cnt + 1'b1;
                first <= 1'b1;
            end
            if (last)
                dcnt <= DRAIN_INIT;
            else if (state == DRAIN && dcnt != '0)
                dcnt <= dcnt - 1'b1;
            if (state == DRAIN && dcnt == '0)
                result <= dsp_p;
        end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: random and directed dot-product jobs against a DSP48E2 pipeline model,
// results checked by a scoreboard monitor against plain bias + sum-of-products arithmetic.
module tb_dsp_mac_sequencer;
    localparam logic [8:0] ACC = 9'h025;
`ifdef DSP_MAC_BIAS_EN
    localparam logic [8:0] FIRST = 9'h035;
    localparam bit BIAS_EN = 1'b1;
`else
    localparam logic [8:0] FIRST = 9'h005;
    localparam bit BIAS_EN = 1'b0;
`endif
    localparam int RES_LAT = 5;

    logic clk = 0, rst = 1, start = 0, in_valid = 0, result_ready = 0;
    logic [7:0] len = 0;
    logic [47:0] bias = 0;
    logic [17:0] in_a = 0, in_b = 0;
    logic in_ready, result_valid, busy;
    logic [17:0] dsp_a, dsp_b;
    logic [47:0] dsp_c, dsp_p, result;
    logic [8:0] dsp_opmode;

    int tests = 0, fails = 0;
    logic [47:0] exp_q[$];
    logic signed [17:0] pa[64], pb[64];

    dsp_mac_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_opmode(dsp_opmode),
        .dsp_p(dsp_p), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // DSP48E2 with AREG/BREG/CREG/MREG/PREG/OPMODEREG = 1, never reset
    logic signed [17:0] ar = 0, br = 0;
    logic signed [35:0] m = 0;
    logic [8:0] opr = 0;
    logic [47:0] cr = 0, p = 0;
    always @(posedge clk) begin
        ar <= dsp_a;
        br <= dsp_b;
        m <= ar * br;
        opr <= dsp_opmode;
        cr <= dsp_c;
        p <= (opr[6:4] == 3'b011 ? cr : opr[6:4] == 3'b010 ? p : 48'h0)
           + (opr[3:0] == 4'h5 ? {{12{m[35]}}, m} : 48'h0);
    end
    assign dsp_p = p;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [47:0] ref_dot(input int n, input logic [47:0] b);
        longint s = BIAS_EN ? longint'(b) : 0;
        for (int i = 0; i < n; i++) s += longint'(pa[i]) * longint'(pb[i]);
        return s[47:0];
    endfunction

    always @(negedge clk)
        if (!rst && result_valid && result_ready) begin
            if (exp_q.size() == 0)
                chk("unexpected_result", 1, 0);
            else
                chk("result", result, exp_q.pop_front());
        end

    task automatic job(input int n, input logic [47:0] bv, input int gap, input int hold, input int stop);
        int k;
        logic [47:0] r;
        result_ready = (hold == 0);
        start = 1; len = n[7:0]; bias = bv;
        @(posedge clk); #1;
        start = 0;
        exp_q.push_back(ref_dot(n, bv));
        for (int i = 0; i < stop; i++) begin
            in_a = pa[i]; in_b = pb[i]; in_valid = 1;
            k = 0;
            while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
            chk("in_ready", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 0;
            if (i < n - 1)
                for (int j = 1; j <= gap; j++) begin
                    @(posedge clk); #1;
                    chk("bubble_opmode", dsp_opmode, (i == 0 && j == 1) ? FIRST : ACC);
                end
        end
        if (stop < n) return;
        k = 0;
        while (!result_valid && k < 50) begin @(posedge clk); #1; k++; end
        chk("latency", k, RES_LAT);
        if (hold > 0) begin
            r = result;
            for (int j = 0; j < hold; j++) begin
                if (j == 1) begin start = 1; len = 8'd2; end
                @(posedge clk); #1;
                start = 0;
                chk("held_valid", {busy, result_valid}, 2'b11);
                chk("held_result", result, r);
            end
            result_ready = 1;
        end
        @(posedge clk); #1;
        result_ready = 0;
        chk("idle_after_consume", {busy, result_valid, in_ready}, 0);
    endtask

    task automatic set3;
        pa[0] = 2; pb[0] = 3; pa[1] = 4; pb[1] = 5; pa[2] = 6; pb[2] = 7;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rb;
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_dsp_ab", {dsp_a, dsp_b}, 0);
        chk("rst_dsp_c", dsp_c, 0);
        chk("rst_opmode", dsp_opmode, 0);
        chk("rst_result", {result, result_valid}, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        @(posedge clk); #1;
        set3();
        job(3, 48'd1, 0, 0, 3);
        job(3, 48'd1, 2, 0, 3);
        pa[0] = -18'sd131072; pb[0] = -18'sd131072;
        job(1, 48'd0, 0, 0, 1);
        start = 1; len = 0; bias = 48'd9;
        @(posedge clk); #1;
        start = 0;
        chk("len0_busy", busy, 0);
        @(posedge clk); #1;
        chk("len0_in_ready", {busy, in_ready}, 0);
        set3();
        job(3, 48'd1, 0, 10, 3);
        for (int i = 0; i < 4; i++) begin pa[i] = 18'sd7 + 18'(i); pb[i] = -18'sd3; end
        job(4, 48'd11, 0, 0, 2);
        rst = 1;
        #1;
        chk("abort_ctrl", {in_ready, busy, result_valid}, 0);
        chk("abort_dsp", {dsp_a, dsp_b, dsp_opmode}, 0);
        chk("abort_result", result, 0);
        chk("abort_dsp_c", dsp_c, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        pa[0] = 1; pb[0] = 1; pa[1] = 1; pb[1] = 1;
        job(2, 48'd5, 0, 0, 2);
        pa[0] = 3; pb[0] = 3; pa[1] = 2; pb[1] = 2;
        job(2, 48'd100, 1, 0, 2);
        for (int t = 0; t < 12; t++) begin
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) begin pa[i] = 18'($urandom); pb[i] = 18'($urandom); end
            rb = {$urandom, $urandom};
            job(n, rb[47:0], int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), n);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
